// File: rtl/hifp_mem_pkg.sv
`default_nettype none
// Shared widths, FSM state and port identifiers for the hifp local-memory responder.
package hifp_mem_pkg;

    localparam int DATA_W  = 512;
    localparam int BE_W    = 64;
    localparam int ADDR_W  = 32;
    localparam int BURST_W = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    // A burstcount of zero is executed as a single beat.
    function automatic logic [BURST_W-1:0] burst_beats(input logic [BURST_W-1:0] bc);
        return (bc == '0) ? BURST_W'(1) : bc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hifp_local_mem_responder_if.sv
`default_nettype none
// Avalon-MM bus bundle for one local-memory port (command, write data, responses).
interface hifp_local_mem_responder_if;
    import hifp_mem_pkg::*;

    logic [ADDR_W-1:0]  address;
    logic               read;
    logic               write;
    logic [DATA_W-1:0]  writedata;
    logic [BE_W-1:0]    byteenable;
    logic [BURST_W-1:0] burstcount;
    logic               waitrequest;
    logic [DATA_W-1:0]  readdata;
    logic               readdatavalid;
    logic               writeack;

    modport master (
        output address, read, write, writedata, byteenable, burstcount,
        input  waitrequest, readdata, readdatavalid, writeack
    );

    modport slave (
        input  address, read, write, writedata, byteenable, burstcount,
        output waitrequest, readdata, readdatavalid, writeack
    );

endinterface
`default_nettype wire

// File: rtl/hifp_mem_ram.sv
`default_nettype none
// Single-port RAM with per-byte write enables and a registered read port.
module hifp_mem_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 512,
    parameter int BE_W   = 64
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [BE_W-1:0]          be_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/hifp_local_mem_responder.sv
`default_nettype none
// Two-port Avalon-MM burst responder sharing one single-port 512-bit RAM,
// with round-robin arbitration and a port-tagged read return pipeline.
module hifp_local_mem_responder
    import hifp_mem_pkg::*;
#(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_LSB     = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    hifp_local_mem_responder_if.slave avs_a,
    hifp_local_mem_responder_if.slave avs_b
);

    localparam int AW = $clog2(DEPTH);

    state_t             state_q, state_d;
    port_id_t           last_grant_q, last_grant_d;
    port_id_t           owner_q, owner_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;

    logic [READ_LATENCY-1:0] tag_v_q, tag_v_d;
    logic [READ_LATENCY-1:0] tag_b_q, tag_b_d;
    logic                    wack_a_q, wack_b_q;

    logic               req_a, req_b, grant_a, grant_b;
    port_id_t           mux_port;
    logic               m_write;
    logic [AW-1:0]      m_word;
    logic [BURST_W-1:0] m_beats;
    logic [DATA_W-1:0]  m_wdata;
    logic [BE_W-1:0]    m_be;

    logic               beat_rd, beat_wr;
    logic [AW-1:0]      beat_addr;
    logic [DATA_W-1:0]  ram_rdata, rd_data;
    logic               rv_a, rv_b;
    logic               addr_bits_unused;

    assign addr_bits_unused = ^{avs_a.address[ADDR_W-1:ADDR_LSB+AW], avs_a.address[ADDR_LSB-1:0],
                                avs_b.address[ADDR_W-1:ADDR_LSB+AW], avs_b.address[ADDR_LSB-1:0]};

    // Arbitration and command mux: in a burst the owner's bus is the only one looked at.
    always_comb begin
        req_a   = avs_a.read | avs_a.write;
        req_b   = avs_b.read | avs_b.write;
        grant_a = (state_q == IDLE) && req_a && (!req_b || last_grant_q == PORT_B);
        grant_b = (state_q == IDLE) && req_b && !grant_a;
        if (state_q == IDLE) begin
            mux_port = grant_b ? PORT_B : PORT_A;
        end else begin
            mux_port = owner_q;
        end
        if (mux_port == PORT_A) begin
            m_write = avs_a.write;
            m_word  = avs_a.address[ADDR_LSB +: AW];
            m_beats = burst_beats(avs_a.burstcount);
            m_wdata = avs_a.writedata;
            m_be    = avs_a.byteenable;
        end else begin
            m_write = avs_b.write;
            m_word  = avs_b.address[ADDR_LSB +: AW];
            m_beats = burst_beats(avs_b.burstcount);
            m_wdata = avs_b.writedata;
            m_be    = avs_b.byteenable;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        beat_rd      = 1'b0;
        beat_wr      = 1'b0;
        beat_addr    = addr_q;
        case (state_q)
            IDLE: begin
                if (grant_a || grant_b) begin
                    last_grant_d = mux_port;
                    beat_addr    = m_word;
                    beat_wr      = m_write;
                    beat_rd      = !m_write;
                    if (m_beats > BURST_W'(1)) begin
                        state_d     = m_write ? WR_BURST : RD_BURST;
                        owner_d     = mux_port;
                        addr_d      = m_word + 1'b1;
                        remaining_d = m_beats - 1'b1;
                    end
                end
            end
            RD_BURST: begin
                beat_rd     = 1'b1;
                addr_d      = addr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == BURST_W'(1)) begin
                    state_d = IDLE;
                end
            end
            WR_BURST: begin
                if (m_write) begin
                    beat_wr     = 1'b1;
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == BURST_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tag_v_d[0] = beat_rd;
        tag_b_d[0] = (mux_port == PORT_B);
        for (int k = 1; k < READ_LATENCY; k++) begin
            tag_v_d[k] = tag_v_q[k-1];
            tag_b_d[k] = tag_b_q[k-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_B;
            owner_q      <= PORT_A;
            addr_q       <= '0;
            remaining_q  <= '0;
            tag_v_q      <= '0;
            tag_b_q      <= '0;
            wack_a_q     <= 1'b0;
            wack_b_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            tag_v_q      <= tag_v_d;
            tag_b_q      <= tag_b_d;
            wack_a_q     <= beat_wr && (mux_port == PORT_A);
            wack_b_q     <= beat_wr && (mux_port == PORT_B);
        end
    end

    hifp_mem_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .BE_W   (BE_W)
    ) u_ram (
        .clk_i   (clock),
        .en_i    ((beat_rd || beat_wr) && !reset),
        .we_i    (beat_wr),
        .addr_i  (beat_addr),
        .wdata_i (m_wdata),
        .be_i    (m_be),
        .rdata_o (ram_rdata)
    );

    // The RAM supplies the first latency stage; the rest are plain data registers.
    if (READ_LATENCY == 1) begin : g_lat1
        assign rd_data = ram_rdata;
    end else begin : g_latn
        logic [DATA_W-1:0] dpipe_q [READ_LATENCY-1];
        always_ff @(posedge clock) begin
            dpipe_q[0] <= ram_rdata;
            for (int k = 1; k < READ_LATENCY-1; k++) begin
                dpipe_q[k] <= dpipe_q[k-1];
            end
        end
        assign rd_data = dpipe_q[READ_LATENCY-2];
    end

    assign rv_a = tag_v_q[READ_LATENCY-1] && !tag_b_q[READ_LATENCY-1];
    assign rv_b = tag_v_q[READ_LATENCY-1] &&  tag_b_q[READ_LATENCY-1];

    assign avs_a.waitrequest   = reset || !(grant_a || (state_q == WR_BURST && owner_q == PORT_A));
    assign avs_b.waitrequest   = reset || !(grant_b || (state_q == WR_BURST && owner_q == PORT_B));
    assign avs_a.readdatavalid = rv_a;
    assign avs_b.readdatavalid = rv_b;
    assign avs_a.readdata      = rv_a ? rd_data : '0;
    assign avs_b.readdata      = rv_b ? rd_data : '0;
    assign avs_a.writeack      = wack_a_q;
    assign avs_b.writeack      = wack_b_q;

endmodule
`default_nettype wire

// File: tb/tb_hifp_local_mem_responder.sv
`default_nettype none
// Directed bench for hifp_local_mem_responder with a read/writeack scoreboard.
module tb_hifp_local_mem_responder;

    localparam int DEPTH = 256;
    localparam int RL    = 2;
    localparam int LSB   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hifp_local_mem_responder_if ia ();
    hifp_local_mem_responder_if ib ();

    logic [31:0]  t_addr [2];
    logic         t_rd   [2];
    logic         t_wr   [2];
    logic [511:0] t_wd   [2];
    logic [63:0]  t_be   [2];
    logic [4:0]   t_bc   [2];
    logic         w_wait [2];
    logic         w_rdv  [2];
    logic         w_wack [2];
    logic [511:0] w_rdata[2];

    assign ia.address = t_addr[0];  assign ib.address = t_addr[1];
    assign ia.read = t_rd[0];       assign ib.read = t_rd[1];
    assign ia.write = t_wr[0];      assign ib.write = t_wr[1];
    assign ia.writedata = t_wd[0];  assign ib.writedata = t_wd[1];
    assign ia.byteenable = t_be[0]; assign ib.byteenable = t_be[1];
    assign ia.burstcount = t_bc[0]; assign ib.burstcount = t_bc[1];
    assign w_wait[0] = ia.waitrequest;   assign w_wait[1] = ib.waitrequest;
    assign w_rdv[0] = ia.readdatavalid;  assign w_rdv[1] = ib.readdatavalid;
    assign w_wack[0] = ia.writeack;      assign w_wack[1] = ib.writeack;
    assign w_rdata[0] = ia.readdata;     assign w_rdata[1] = ib.readdata;

    hifp_local_mem_responder #(
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL),
        .ADDR_LSB     (LSB)
    ) dut (
        .clock (clk),
        .reset (rst),
        .avs_a (ia),
        .avs_b (ib)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int           p;
        logic [511:0] d;
        int           due;
    } exp_t;

    exp_t         sbq[$];
    exp_t         e_mon;
    logic [511:0] model [DEPTH];
    logic         wack_exp [2] = '{1'b0, 1'b0};
    int           wr_left  [2] = '{0, 0};
    int           wr_next  [2] = '{0, 0};
    int           tb_last = 1;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_wr(input int w, input logic [511:0] d, input logic [63:0] be);
        for (int b = 0; b < 64; b++) begin
            if (be[b]) model[w][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    // Scoreboard: tracks accepted beats, predicts writeacks and read returns.
    always @(negedge clk) begin
        cyc++;
        for (int p = 0; p < 2; p++) chk($sformatf("writeack_p%0d", p), w_wack[p], wack_exp[p]);
        if (rst) begin
            sbq.delete();
            for (int p = 0; p < 2; p++) begin
                wack_exp[p] = 1'b0;
                wr_left[p]  = 0;
            end
            tb_last = 1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_rdv[p]) begin
                    if (sbq.size() == 0) begin
                        chk($sformatf("rdv_unexpected_p%0d", p), w_rdv[p], 1'b0);
                    end else begin
                        e_mon = sbq.pop_front();
                        chk("rd_port", p, e_mon.p);
                        chk("rd_data", w_rdata[p], e_mon.d);
                        chk("rd_cycle", cyc, e_mon.due);
                    end
                end
            end
            if (sbq.size() > 0 && sbq[0].due < cyc) begin
                chk("rd_missing_cycle", cyc, sbq[0].due);
                void'(sbq.pop_front());
            end
            for (int p = 0; p < 2; p++) begin
                wack_exp[p] = 1'b0;
                if (!w_wait[p] && t_wr[p]) begin
                    wack_exp[p] = 1'b1;
                    tb_last = p;
                    if (wr_left[p] == 0) begin
                        model_wr(int'(t_addr[p][LSB +: 8]), t_wd[p], t_be[p]);
                        wr_left[p] = (t_bc[p] == 0) ? 0 : int'(t_bc[p]) - 1;
                        wr_next[p] = (int'(t_addr[p][LSB +: 8]) + 1) % DEPTH;
                    end else begin
                        model_wr(wr_next[p], t_wd[p], t_be[p]);
                        wr_left[p]--;
                        wr_next[p] = (wr_next[p] + 1) % DEPTH;
                    end
                end else if (!w_wait[p] && t_rd[p]) begin
                    tb_last = p;
                    for (int n = 0; n < ((t_bc[p] == 0) ? 1 : int'(t_bc[p])); n++) begin
                        sbq.push_back('{p, model[(int'(t_addr[p][LSB +: 8]) + n) % DEPTH], cyc + RL + n});
                    end
                end
            end
        end
    end

    task automatic wait_accept(input int p, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (w_wait[p] !== 1'b0 && n < 64);
        chk($sformatf("accept_p%0d", p), w_wait[p], 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int p, input bit wr, input logic [31:0] a, input logic [511:0] d,
                       input logic [63:0] be, input logic [4:0] bc, output int n);
        t_addr[p] = a; t_wd[p] = d; t_be[p] = be; t_bc[p] = bc;
        t_wr[p] = wr; t_rd[p] = !wr;
        wait_accept(p, n);
        t_wr[p] = 1'b0; t_rd[p] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int p = 0; p < 2; p++) begin
            t_addr[p] = '0; t_rd[p] = 1'b0; t_wr[p] = 1'b0;
            t_wd[p] = '0; t_be[p] = '1; t_bc[p] = 5'd1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("reset_wait_p%0d", p), w_wait[p], 1'b1);
            chk($sformatf("reset_rdv_p%0d", p), w_rdv[p], 1'b0);
            chk($sformatf("reset_rdata_p%0d", p), w_rdata[p], '0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // B single write, A read of the same word
        cmd(1, 1'b1, 32'h40, {64{8'hAB}}, '1, 5'd1, n);
        cmd(0, 1'b0, 32'h40, '0, '1, 5'd1, n);
        drain();

        // A write burst of 4 with a two-cycle stall, then read it back
        t_addr[0] = 32'h0; t_bc[0] = 5'd4; t_be[0] = '1; t_wr[0] = 1'b1;
        t_wd[0] = 512'd1;
        wait_accept(0, n);
        t_wd[0] = 512'd2;
        wait_accept(0, n);
        chk("burst_beat2_no_wait", n, 1);
        t_wr[0] = 1'b0; t_addr[0] = 32'h1000; t_bc[0] = 5'd1;
        repeat (2) begin
            @(negedge clk);
            chk("stall_wait_b", w_wait[1], 1'b1);
            chk("stall_wait_a", w_wait[0], 1'b0);
            @(posedge clk);
            #1;
        end
        t_wr[0] = 1'b1; t_wd[0] = 512'd3;
        wait_accept(0, n);
        chk("stall_wait_b_beat3", w_wait[1], 1'b1);
        t_wd[0] = 512'd4;
        wait_accept(0, n);
        t_wr[0] = 1'b0;
        cmd(0, 1'b0, 32'h0, '0, '1, 5'd4, n);
        drain();

        // Contention: B goes first alone, then both read and grants alternate A,B,A,B
        cmd(1, 1'b0, 32'h0, '0, '1, 5'd1, n);
        t_addr[0] = 32'h80; t_addr[1] = 32'h40; t_bc[0] = 5'd1; t_bc[1] = 5'd1;
        t_rd[0] = 1'b1; t_rd[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("contend_grant_%0d", i), {w_wait[1], w_wait[0]}, (i % 2 == 0) ? 2'b10 : 2'b01);
            @(posedge clk);
            #1;
        end
        t_rd[0] = 1'b0; t_rd[1] = 1'b0;
        drain();

        // Wrap: burst of 2 at the last word, then aliased reads
        t_addr[1] = 32'h3FC0; t_bc[1] = 5'd2; t_be[1] = '1; t_wr[1] = 1'b1;
        t_wd[1] = {16{32'hCAFE_0001}};
        wait_accept(1, n);
        t_wd[1] = {16{32'hCAFE_0002}};
        wait_accept(1, n);
        t_wr[1] = 1'b0;
        cmd(0, 1'b0, 32'h4000, '0, '1, 5'd1, n);
        cmd(0, 1'b0, 32'h3FC0, '0, '1, 5'd1, n);
        cmd(1, 1'b0, 32'h0, '0, '1, 5'd0, n);
        drain();

        // Partial byteenable over an all-ones word
        cmd(0, 1'b1, 32'hC0, {64{8'hFF}}, '1, 5'd1, n);
        cmd(0, 1'b1, 32'hC0, '0, 64'h1, 5'd1, n);
        cmd(0, 1'b0, 32'hC0, '0, '1, 5'd1, n);
        drain();

        // Reset during a 16-beat read burst after three beats
        cmd(0, 1'b0, 32'h0, '0, '1, 5'd16, n);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("midreset_rdv_p%0d", p), w_rdv[p], 1'b0);
            chk($sformatf("midreset_wait_p%0d", p), w_wait[p], 1'b1);
            chk($sformatf("midreset_rdata_p%0d", p), w_rdata[p], '0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        cmd(0, 1'b0, 32'hC0, '0, '1, 5'd1, n);
        chk("post_reset_accept_cycles", n, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hifp_local_mem_responder.md
Name: hifp_local_mem_responder

Overview:
- Avalon-MM slave memory bank: the responder end of the 512-bit local-memory master ports that the hifp kernel functions drive for their load and store sites.
- Two slave ports, A (load site) and B (store site), share one internal single-port RAM of 512-bit words.
- Round-robin arbitration between ports; bursts of up to 16 beats; per-beat readdatavalid and writeack.
- Instantiated beside each hifp RTL function inside the kernel wrapper.

Parameters:
- DEPTH, 256: number of 512-bit words, power of two.
- READ_LATENCY, 2: cycles from read-beat issue to readdatavalid, range 1..4.
- ADDR_LSB, 6: byte-to-word address shift (64-byte words).

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- avs_a_address  in  32  byte address
- avs_a_read  in  1  read request
- avs_a_write  in  1  write request
- avs_a_writedata  in  512  write data
- avs_a_byteenable  in  64  per-byte write enable
- avs_a_burstcount  in  5  beats 1..16; 0 is treated as 1
- avs_a_waitrequest  out  1  command/beat not accepted this cycle
- avs_a_readdata  out  512  read data
- avs_a_readdatavalid  out  1  readdata valid
- avs_a_writeack  out  1  one pulse per accepted write beat
- avs_b_*  identical set for port B

Behaviour:
- Reset:
  - All readdatavalid, writeack and readdata outputs are 0; both waitrequests are 1.
  - FSM goes to IDLE, last_grant=B, so A wins first contention.
  - Read pipeline is flushed; RAM contents are undefined.
- Address handling:
  - word = address[ADDR_LSB +: log2(DEPTH)]; higher bits are ignored (wraps modulo DEPTH).
  - Burst beat n uses (word+n) mod DEPTH.
- Request definition: req_X = read_X | write_X. If both read and write are high on one port, the write is taken and the read ignored.
- FSM states:
  - IDLE
    - One requester: it is granted.
    - Both requesting: the port != last_grant is granted.
    - Granted port: waitrequest=0. Other port: waitrequest=1.
    - First beat executes this cycle; last_grant is updated.
    - burstcount<=1: stay in IDLE.
    - Read with burstcount>1: go to RD_BURST, remaining=burstcount-1.
    - Write with burstcount>1: go to WR_BURST, remaining=burstcount-1.
  - RD_BURST
    - Both waitrequests are 1.
    - One read beat is issued per cycle at the incrementing address.
    - remaining decrements each beat; return to IDLE after the beat with remaining==1.
  - WR_BURST
    - Owner waitrequest = 0, other port = 1.
    - A beat is accepted only when owner write=1; owner write=0 stalls with no RAM access.
    - Address increments per accepted beat; return to IDLE after the last beat.
    - Address and burstcount inputs are ignored during this state.
- Write data path: accepted write beat → RAM bytes with byteenable=1 are written in the same cycle. Owner writeack pulses 1 cycle later.
- Read return path:
  - Each issued read beat enters a READ_LATENCY-deep shift pipeline tagged with the port.
  - At pipeline exit, only that port's readdatavalid=1 and readdata = word.
  - Return order equals issue order, one beat per cycle max.
- Waitrequest: combinational from FSM state, last_grant and the req inputs; no registered allowance.
- Throughput: back-to-back single-beat commands, one per cycle. Under continuous contention, grants alternate A/B.
- Hazards: read issued in the cycle after a write to the same word returns the new data; no same-cycle read/write is possible on the single-port RAM.
- Reset mid-burst: burst aborted; in-flight read beats dropped, with no readdatavalid after reset.

Decomposition:
- Shared package hifp_mem_pkg:
  - constants DATA_W=512, BE_W=64, ADDR_W=32, BURST_W=5
  - FSM state enum {IDLE, RD_BURST, WR_BURST}
  - port id type (A=0, B=1)
- Sub-module hifp_mem_ram: single-port 512-bit RAM with byte enables and registered read; the remaining READ_LATENCY-1 stages stay in the top level.

Test Plan:
- Port B single write, addr 0x40, data 0xAB.., byteenable all ones → writeack_b 1 cycle later. Port A read at 0x40 → readdatavalid_a exactly 2 cycles after acceptance with 0xAB...
- Port A write burst of 4 at 0x0 with data 1,2,3,4; write deasserted for 2 cycles mid-burst → 4 writeack pulses, B waitrequest=1 throughout. Port A read burst of 4 → readdatavalid on 4 consecutive cycles returning 1,2,3,4.
- A and B read simultaneously for 4 cycles → grants in order A,B,A,B; each port's data returns in order on its own readdatavalid.
- Write at word DEPTH-1 with burstcount 2 → second beat lands at word 0. Address 0x4000 (DEPTH=256) aliases word 0.
- Byteenable = 64'h1 over an existing word of all 0xFF with data 0 → read returns 0xFF..FF00.
- Reset asserted during a 16-beat read burst after 3 beats → outputs immediately return to their reset values; no further readdatavalid; the next A read is accepted in IDLE.
